mlsu_addr_gen: RTL and testbench

- Matrix LSU address generator, directly downstream of the request pre-decoder. Consumes one pre-decoded row/column request per handshake.
- Expands each request into bus transactions on a valid/ready channel feeding the memory-port adapter.
- Unit-stride (row-major) requests become aligned multi-beat bursts that never cross a 4 KiB page or exceed MAX_BEATS.
- Strided (column-major) requests become one single-beat transaction per element.

---
 rtl/mlsu_addr_gen.sv | 247 ++++++++++++++++++++++++
 tb/tb_mlsu_addr_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mlsu_addr_gen.sv
// ---------------------------------------------------------------------------
// mlsu_addr_gen
// Matrix LSU address generator. Takes one pre-decoded row/column request per
// handshake and expands it into bus transactions for the memory-port adapter.
//   - Row-major (unit-stride) requests become aligned multi-beat bursts that
//     never cross a 4 KiB page and never exceed MAX_BEATS beats.
//   - Column-major (strided) requests become one single-beat transaction per
//     element.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_valid_i/ready_o   request handshake
//   req_id_i              request id, copied to every transaction
//   req_mode_i            2'b01 row-major, 2'b10 column-major (one-hot)
//   req_base_addr_i       byte base address
//   req_stride_i          byte stride between elements (column-major)
//   req_sew_i             log2 of element size in bytes
//   req_vl_i              end element index (exclusive)
//   req_vstart_i          first element index
//   req_is_load_i         1 = load, 0 = store
//   txn_valid_o/ready_i   transaction handshake
//   txn_addr_o            transaction start byte address
//   txn_len_o             beats minus one
//   txn_size_o            log2 bytes per beat
//   txn_id_o              request id
//   txn_is_load_o         load/store flag
//   txn_last_o            final transaction of the current request
//
// Optional build macro MLSU_ADDR_GEN_STATS_EN adds:
//   stat_txn_cnt_o        wrapping count of transaction handshakes
//   stat_req_cnt_o        wrapping count of accepted requests
// ---------------------------------------------------------------------------
module mlsu_addr_gen #(
    parameter int AW        = 64,
    parameter int VL_W      = 16,
    parameter int ID_W      = 4,
    parameter int BUS_BYTES = 16,
    parameter int MAX_BEATS = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [ID_W-1:0] req_id_i,
    input  logic [1:0]      req_mode_i,
    input  logic [AW-1:0]   req_base_addr_i,
    input  logic [AW-1:0]   req_stride_i,
    input  logic [1:0]      req_sew_i,
    input  logic [VL_W-1:0] req_vl_i,
    input  logic [VL_W-1:0] req_vstart_i,
    input  logic            req_is_load_i,
    output logic            txn_valid_o,
    input  logic            txn_ready_i,
    output logic [AW-1:0]   txn_addr_o,
    output logic [7:0]      txn_len_o,
    output logic [2:0]      txn_size_o,
    output logic [ID_W-1:0] txn_id_o,
    output logic            txn_is_load_o,
    output logic            txn_last_o
`ifdef MLSU_ADDR_GEN_STATS_EN
    ,
    output logic [31:0]     stat_txn_cnt_o,
    output logic [31:0]     stat_req_cnt_o
`endif
);

    localparam int OFF_W       = $clog2(BUS_BYTES);
    // Wide enough for (vl - vstart) << 3 and for MAX_BEATS*BUS_BYTES (<= 16384).
    localparam int CW          = (VL_W + 4 > 16) ? VL_W + 4 : 16;
    localparam int BURST_BYTES = MAX_BEATS * BUS_BYTES;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cur_addr_q;
    logic [CW-1:0]   rem_q;
    logic [AW-1:0]   stride_q;
    logic [1:0]      sew_q;
    logic [ID_W-1:0] id_q;
    logic            is_load_q;
    logic            col_q;
    logic            live_q;

    logic            accept;
    logic            fire;
    logic            req_empty;
    logic [VL_W-1:0] elem_cnt;
    logic [AW-1:0]   start_addr;
    logic [CW-1:0]   start_rem;

    logic [CW-1:0]   off_c;
    logic [CW-1:0]   to_page_c;
    logic [CW-1:0]   room_c;
    logic [CW-1:0]   bytes_c;
    logic [CW-1:0]   beats_c;
    logic [7:0]      row_len_c;
    logic            last_c;

    // live_q keeps req_ready_o low while reset is held and until the first
    // clock edge after release.
    assign req_ready_o = live_q && (state_q == IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign fire        = txn_valid_o && txn_ready_i;

    // Capture-side arithmetic. A column-major request starts vstart elements
    // into the column, i.e. vstart strides past the base; a row-major request
    // starts vstart elements past the base.
    assign req_empty = (req_vl_i <= req_vstart_i);
    assign elem_cnt  = req_vl_i - req_vstart_i;

    always_comb begin
        start_addr = '0;
        start_rem  = '0;
        if (req_mode_i[1]) begin
            start_addr = req_base_addr_i + req_stride_i * AW'(req_vstart_i);
            start_rem  = CW'(elem_cnt);
        end else begin
            start_addr = req_base_addr_i + (AW'(req_vstart_i) << req_sew_i);
            start_rem  = CW'(elem_cnt) << req_sew_i;
        end
    end

    // Row-major burst sizing from registered state only, so a new burst can be
    // presented in the cycle right after the previous handshake.
    always_comb begin
        off_c     = CW'(cur_addr_q[OFF_W-1:0]);
        to_page_c = CW'(13'd4096 - {1'b0, cur_addr_q[11:0]});
        room_c    = CW'(BURST_BYTES) - off_c;
        bytes_c   = rem_q;
        if (to_page_c < bytes_c) begin
            bytes_c = to_page_c;
        end
        if (room_c < bytes_c) begin
            bytes_c = room_c;
        end
        beats_c   = (off_c + bytes_c + CW'(BUS_BYTES - 1)) >> OFF_W;
        row_len_c = 8'(beats_c - CW'(1));
        last_c    = col_q ? (rem_q == CW'(1)) : (bytes_c == rem_q);
    end

    // Transaction outputs are forced to zero outside ISSUE; inside ISSUE they
    // derive from registers that only move on a handshake, so they stay
    // stable under backpressure.
    always_comb begin
        txn_valid_o   = 1'b0;
        txn_addr_o    = '0;
        txn_len_o     = '0;
        txn_size_o    = '0;
        txn_id_o      = '0;
        txn_is_load_o = 1'b0;
        txn_last_o    = 1'b0;
        if (state_q == ISSUE) begin
            txn_valid_o   = 1'b1;
            txn_addr_o    = cur_addr_q;
            txn_len_o     = col_q ? 8'd0 : row_len_c;
            txn_size_o    = col_q ? {1'b0, sew_q} : 3'(OFF_W);
            txn_id_o      = id_q;
            txn_is_load_o = is_load_q;
            txn_last_o    = last_c;
        end
    end

    // Next-state logic: an empty request is swallowed in IDLE; the handshake
    // of the last transaction returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !req_empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fire && last_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    // Request capture and per-transaction advance of address and remainder.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_addr_q <= '0;
            rem_q      <= '0;
            stride_q   <= '0;
            sew_q      <= '0;
            id_q       <= '0;
            is_load_q  <= 1'b0;
            col_q      <= 1'b0;
        end else if (accept) begin
            cur_addr_q <= start_addr;
            rem_q      <= req_empty ? '0 : start_rem;
            stride_q   <= req_stride_i;
            sew_q      <= req_sew_i;
            id_q       <= req_id_i;
            is_load_q  <= req_is_load_i;
            col_q      <= req_mode_i[1];
        end else if (fire) begin
            if (col_q) begin
                cur_addr_q <= cur_addr_q + stride_q;
                rem_q      <= rem_q - CW'(1);
            end else begin
                cur_addr_q <= cur_addr_q + AW'(bytes_c);
                rem_q      <= rem_q - bytes_c;
            end
        end
    end

`ifdef MLSU_ADDR_GEN_STATS_EN
    // Free-running wrapping activity counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_txn_cnt_o <= '0;
            stat_req_cnt_o <= '0;
        end else begin
            if (fire) begin
                stat_txn_cnt_o <= stat_txn_cnt_o + 32'd1;
            end
            if (accept) begin
                stat_req_cnt_o <= stat_req_cnt_o + 32'd1;
            end
        end
    end
`endif

    // Only one-hot modes are meaningful on acceptance.
    a_legal_mode: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> (req_mode_i == 2'b01 || req_mode_i == 2'b10))
        else $error("mlsu_addr_gen: illegal req_mode_i 0x%0h", req_mode_i);

endmodule

// File: tb/tb_mlsu_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_mlsu_addr_gen
// Directed self-checking bench for mlsu_addr_gen with default parameters
// (BUS_BYTES=16, MAX_BEATS=16). Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_mlsu_addr_gen;

    localparam int AW   = 64;
    localparam int VL_W = 16;
    localparam int ID_W = 4;

    logic            clk_i;
    logic            rst_ni;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [ID_W-1:0] req_id_i;
    logic [1:0]      req_mode_i;
    logic [AW-1:0]   req_base_addr_i;
    logic [AW-1:0]   req_stride_i;
    logic [1:0]      req_sew_i;
    logic [VL_W-1:0] req_vl_i;
    logic [VL_W-1:0] req_vstart_i;
    logic            req_is_load_i;
    logic            txn_valid_o;
    logic            txn_ready_i;
    logic [AW-1:0]   txn_addr_o;
    logic [7:0]      txn_len_o;
    logic [2:0]      txn_size_o;
    logic [ID_W-1:0] txn_id_o;
    logic            txn_is_load_o;
    logic            txn_last_o;
`ifdef MLSU_ADDR_GEN_STATS_EN
    logic [31:0]     stat_txn_cnt_o;
    logic [31:0]     stat_req_cnt_o;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [ID_W-1:0] exp_id;
    logic            exp_load;

    mlsu_addr_gen #(
        .AW       (AW),
        .VL_W     (VL_W),
        .ID_W     (ID_W),
        .BUS_BYTES(16),
        .MAX_BEATS(16)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_id_i       (req_id_i),
        .req_mode_i     (req_mode_i),
        .req_base_addr_i(req_base_addr_i),
        .req_stride_i   (req_stride_i),
        .req_sew_i      (req_sew_i),
        .req_vl_i       (req_vl_i),
        .req_vstart_i   (req_vstart_i),
        .req_is_load_i  (req_is_load_i),
        .txn_valid_o    (txn_valid_o),
        .txn_ready_i    (txn_ready_i),
        .txn_addr_o     (txn_addr_o),
        .txn_len_o      (txn_len_o),
        .txn_size_o     (txn_size_o),
        .txn_id_o       (txn_id_o),
        .txn_is_load_o  (txn_is_load_o),
        .txn_last_o     (txn_last_o)
`ifdef MLSU_ADDR_GEN_STATS_EN
        ,
        .stat_txn_cnt_o (stat_txn_cnt_o),
        .stat_req_cnt_o (stat_req_cnt_o)
`endif
    );

    // 100 MHz-style free-running clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Presents one request for a single cycle; called on a falling edge and
    // returns on the next falling edge, after the DUT has accepted it.
    task automatic applyStimulus(input logic [ID_W-1:0] id, input logic [1:0] mode,
                                 input logic [AW-1:0] base, input logic [AW-1:0] stride,
                                 input logic [1:0] sew, input logic [VL_W-1:0] vl,
                                 input logic [VL_W-1:0] vstart, input logic is_load);
        req_id_i        = id;
        req_mode_i      = mode;
        req_base_addr_i = base;
        req_stride_i    = stride;
        req_sew_i       = sew;
        req_vl_i        = vl;
        req_vstart_i    = vstart;
        req_is_load_i   = is_load;
        req_valid_i     = 1'b1;
        exp_id          = id;
        exp_load        = is_load;
        checkOutput("req_ready_before_accept", 64'(req_ready_o), 64'd1);
        @(negedge clk_i);
        req_valid_i     = 1'b0;
    endtask

    // Checks the transaction on the bus now, then steps one cycle (the
    // handshake happens on the intervening rising edge if txn_ready_i=1).
    task automatic expectTxn(input string tag, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic last);
        checkOutput({tag, "_valid"}, 64'(txn_valid_o), 64'd1);
        checkOutput({tag, "_addr"},  64'(txn_addr_o),  64'(addr));
        checkOutput({tag, "_len"},   64'(txn_len_o),   64'(len));
        checkOutput({tag, "_size"},  64'(txn_size_o),  64'(size));
        checkOutput({tag, "_last"},  64'(txn_last_o),  64'(last));
        checkOutput({tag, "_id"},    64'(txn_id_o),    64'(exp_id));
        checkOutput({tag, "_load"},  64'(txn_is_load_o), 64'(exp_load));
        @(negedge clk_i);
    endtask

    // Checks that the block is back in IDLE.
    task automatic expectIdle(input string tag);
        checkOutput({tag, "_valid"}, 64'(txn_valid_o), 64'd0);
        checkOutput({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    endtask

    initial begin
        rst_ni          = 1'b0;
        req_valid_i     = 1'b0;
        req_id_i        = '0;
        req_mode_i      = 2'b01;
        req_base_addr_i = '0;
        req_stride_i    = '0;
        req_sew_i       = '0;
        req_vl_i        = '0;
        req_vstart_i    = '0;
        req_is_load_i   = 1'b0;
        txn_ready_i     = 1'b1;
        exp_id          = '0;
        exp_load        = 1'b0;

        // Reset state.
        #12;
        checkOutput("rst_req_ready", 64'(req_ready_o), 64'd0);
        checkOutput("rst_txn_valid", 64'(txn_valid_o), 64'd0);
        checkOutput("rst_txn_addr",  64'(txn_addr_o),  64'd0);
        checkOutput("rst_txn_len",   64'(txn_len_o),   64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        expectIdle("post_rst");

        // Row, single aligned burst of 32 bytes.
        applyStimulus(4'h3, 2'b01, 64'h1000, 64'h0, 2'd2, 16'd8, 16'd0, 1'b1);
        expectTxn("row1_t0", 64'h1000, 8'd1, 3'd4, 1'b1);
        expectIdle("row1_end");

        // Row, crossing a 4 KiB page boundary.
        applyStimulus(4'h5, 2'b01, 64'h1FF8, 64'h0, 2'd3, 16'd4, 16'd0, 1'b0);
        expectTxn("row2_t0", 64'h1FF8, 8'd0, 3'd4, 1'b0);
        expectTxn("row2_t1", 64'h2000, 8'd1, 3'd4, 1'b1);
        expectIdle("row2_end");

        // Row, 300 bytes capped at MAX_BEATS, with 5 cycles of backpressure.
        applyStimulus(4'h6, 2'b01, 64'h0, 64'h0, 2'd0, 16'd300, 16'd0, 1'b1);
        txn_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checkOutput("bp_valid", 64'(txn_valid_o), 64'd1);
            checkOutput("bp_addr",  64'(txn_addr_o),  64'h0);
            checkOutput("bp_len",   64'(txn_len_o),   64'd15);
            checkOutput("bp_last",  64'(txn_last_o),  64'd0);
            checkOutput("bp_ready", 64'(req_ready_o), 64'd0);
        end
        txn_ready_i = 1'b1;
        expectTxn("row3_t0", 64'h0,   8'd15, 3'd4, 1'b0);
        expectTxn("row3_t1", 64'h100, 8'd2,  3'd4, 1'b1);
        expectIdle("row3_end");

        // Column, stride 0x40, starting at element 1.
        applyStimulus(4'h7, 2'b10, 64'h100, 64'h40, 2'd1, 16'd3, 16'd1, 1'b0);
        expectTxn("col_t0", 64'h140, 8'd0, 3'd1, 1'b0);
        expectTxn("col_t1", 64'h180, 8'd0, 3'd1, 1'b1);
        expectIdle("col_end");

        // Empty request: consumed with no transaction.
        applyStimulus(4'h8, 2'b01, 64'h500, 64'h0, 2'd2, 16'd5, 16'd5, 1'b1);
        expectIdle("empty_0");
        @(negedge clk_i);
        expectIdle("empty_1");

        // Reset pulsed while a transaction is pending.
        applyStimulus(4'h9, 2'b01, 64'h1000, 64'h0, 2'd2, 16'd8, 16'd0, 1'b1);
        checkOutput("abort_issue_valid", 64'(txn_valid_o), 64'd1);
        txn_ready_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("abort_valid", 64'(txn_valid_o), 64'd0);
        checkOutput("abort_ready", 64'(req_ready_o), 64'd0);
        checkOutput("abort_addr",  64'(txn_addr_o),  64'd0);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        txn_ready_i = 1'b1;
        @(negedge clk_i);
        expectIdle("abort_release");

        // Normal operation after the abort.
        applyStimulus(4'hA, 2'b01, 64'h1000, 64'h0, 2'd2, 16'd8, 16'd0, 1'b0);
        expectTxn("after_abort_t0", 64'h1000, 8'd1, 3'd4, 1'b1);
        expectIdle("after_abort_end");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
